fp_summator: RTL and testbench

Single-precision (IEEE-754 binary32) floating-point adder with a registered result. Operands are added by a combinational datapath, and the result is captured in an output register on the clock edge when `vld_i` is high. The block is the arithmetic leaf used by the FPU blocks of the basic-arithmetic section. It shares its operand types with the rest of the FPU through `float_types_pkg`.

---
 rtl/float_types_pkg.sv | 39 +++
 rtl/fp_add_core.sv | 129 ++++++++++++
 rtl/fp_summator.sv | 43 ++++
 tb/tb_fp_summator.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/float_types_pkg.sv
// Shared binary32 operand/status types for the FPU arithmetic blocks.
// Classification helpers treat exp==0 as zero regardless of mantissa.
package float_types_pkg;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } float_point_num;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_OK   = 3'd1,
      ST_OVF  = 3'd2,
      ST_UNF  = 3'd3,
      ST_NAN  = 3'd4,
      ST_INF  = 3'd5
   } fp_status_t;

   localparam int          EXP_BIAS = 127;
   localparam int          EXP_MAX  = 255;
   localparam logic [31:0] QNAN     = 32'h7FC00000;

   // Hidden bit + 23 mantissa bits + guard/round/sticky.
   localparam int          SIG_W    = 27;

   function automatic logic is_nan(input float_point_num x);
      return (x.exp == 8'(EXP_MAX)) && (x.mant != '0);
   endfunction

   function automatic logic is_inf(input float_point_num x);
      return (x.exp == 8'(EXP_MAX)) && (x.mant == '0);
   endfunction

   function automatic logic is_zero(input float_point_num x);
      return x.exp == '0;
   endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational binary32 adder: align, add/subtract, normalise, RNE round,
// then flush/overflow/special-case selection. No state.
module fp_add_core
   import float_types_pkg::*;
(
   input  float_point_num a_i,
   input  float_point_num b_i,
   output float_point_num sum_o,
   output fp_status_t     status_o
);

   // Right shift that folds every shifted-out bit into the sticky LSB.
   function automatic logic [SIG_W-1:0] align(input logic [SIG_W-1:0] sig,
                                              input logic [7:0]       sh);
      logic [SIG_W-1:0] lost_mask;
      logic [SIG_W-1:0] res;
      if (sh >= 8'(SIG_W)) begin
         res = {{(SIG_W-1){1'b0}}, |sig};
      end else begin
         lost_mask = (SIG_W'(1) << sh) - SIG_W'(1);
         res       = sig >> sh;
         res[0]    = res[0] | (|(sig & lost_mask));
      end
      return res;
   endfunction

   function automatic logic [4:0] lzc(input logic [SIG_W-1:0] v);
      logic [4:0] n;
      n = 5'(SIG_W);
      for (int i = 0; i < SIG_W; i++) begin
         if (v[i]) n = 5'(SIG_W - 1 - i);
      end
      return n;
   endfunction

   // Round-to-nearest-even on G/R/S; bit 24 of the result is the carry-out.
   function automatic logic [24:0] round_rne(input logic [SIG_W-1:0] n);
      logic up;
      up = n[2] & (n[1] | n[0] | n[3]);
      return {1'b0, n[26:3]} + {24'd0, up};
   endfunction

   float_point_num          big, sml;
   logic [SIG_W-1:0]        sig_big, sig_sml, sml_al, sub_res, norm;
   logic [SIG_W:0]          add_res;
   logic [7:0]              diff;
   logic [4:0]              lz;
   logic [24:0]             rnd;
   logic [22:0]             mant_r;
   logic signed [9:0]       exp_n;
   logic                    eff_sub;
   logic                    zero_diff;

   always_comb begin
      sum_o     = '0;
      status_o  = ST_OK;
      norm      = '0;
      lz        = '0;
      zero_diff = 1'b0;

      if ({a_i.exp, a_i.mant} >= {b_i.exp, b_i.mant}) begin
         big = a_i;
         sml = b_i;
      end else begin
         big = b_i;
         sml = a_i;
      end

      // A zero-exponent operand contributes nothing, whatever its mantissa.
      sig_big = is_zero(big) ? '0 : {1'b1, big.mant, 3'b000};
      sig_sml = is_zero(sml) ? '0 : {1'b1, sml.mant, 3'b000};
      diff    = big.exp - sml.exp;
      sml_al  = align(sig_sml, diff);
      add_res = {1'b0, sig_big} + {1'b0, sml_al};
      sub_res = sig_big - sml_al;
      eff_sub = big.sign ^ sml.sign;
      exp_n   = signed'({2'b00, big.exp});

      if (!eff_sub) begin
         if (add_res[SIG_W]) begin
            norm  = {add_res[SIG_W:2], add_res[1] | add_res[0]};
            exp_n = exp_n + 10'sd1;
         end else begin
            norm  = add_res[SIG_W-1:0];
         end
      end else begin
         zero_diff = (sub_res == '0);
         lz        = lzc(sub_res);
         norm      = sub_res << lz;
         exp_n     = exp_n - signed'({5'd0, lz});
      end

      rnd = round_rne(norm);
      if (rnd[24]) begin
         mant_r = rnd[23:1];
         exp_n  = exp_n + 10'sd1;
      end else begin
         mant_r = rnd[22:0];
      end

      if (is_nan(a_i) || is_nan(b_i) ||
          (is_inf(a_i) && is_inf(b_i) && (a_i.sign != b_i.sign))) begin
         sum_o    = QNAN;
         status_o = ST_NAN;
      end else if (is_inf(a_i)) begin
         sum_o    = a_i;
         status_o = ST_INF;
      end else if (is_inf(b_i)) begin
         sum_o    = b_i;
         status_o = ST_INF;
      end else if (is_zero(a_i) && is_zero(b_i)) begin
         sum_o    = '{sign: a_i.sign & b_i.sign, exp: '0, mant: '0};
         status_o = ST_OK;
      end else if (eff_sub && zero_diff) begin
         sum_o    = '0;
         status_o = ST_OK;
      end else if (exp_n >= 10'(EXP_MAX)) begin
         sum_o    = '{sign: big.sign, exp: 8'(EXP_MAX), mant: '0};
         status_o = ST_OVF;
      end else if (exp_n <= 10'sd0) begin
         sum_o    = '{sign: big.sign, exp: '0, mant: '0};
         status_o = ST_UNF;
      end else begin
         sum_o    = '{sign: big.sign, exp: exp_n[7:0], mant: mant_r};
         status_o = ST_OK;
      end
   end

endmodule

// File: rtl/fp_summator.sv
// Binary32 adder with a vld-gated result register; status drops to ST_IDLE
// on cycles without a valid operand pair while the sum is held.
module fp_summator
   import float_types_pkg::*;
(
   input  logic           clk_i,
   input  logic           rst_i,
   input  float_point_num a_i,
   input  float_point_num b_i,
   input  logic           vld_i,
   output float_point_num answer_o,
   output fp_status_t     answer_status_o
);

   float_point_num sum_c, answer_d, answer_q;
   fp_status_t     status_c, status_d, status_q;

   fp_add_core u_core (
      .a_i      (a_i),
      .b_i      (b_i),
      .sum_o    (sum_c),
      .status_o (status_c)
   );

   always_comb begin
      answer_d = vld_i ? sum_c    : answer_q;
      status_d = vld_i ? status_c : ST_IDLE;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         answer_q <= '0;
         status_q <= ST_IDLE;
      end else begin
         answer_q <= answer_d;
         status_q <= status_d;
      end
   end

   assign answer_o        = answer_q;
   assign answer_status_o = status_q;

endmodule

// File: tb/tb_fp_summator.sv
// Bench for fp_summator: exact-arithmetic reference model compared every
// cycle, plus literal vectors pinning both the DUT and the model.
module tb_fp_summator;
   import float_types_pkg::*;

   localparam int VW = 300;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           vld = 1'b0;
   float_point_num a   = '0;
   float_point_num b   = '0;
   float_point_num answer;
   fp_status_t     status;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] exp_ans, t_ans;
   logic [2:0]  exp_st,  t_st;

   fp_summator dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .a_i             (a),
      .b_i             (b),
      .vld_i           (vld),
      .answer_o        (answer),
      .answer_status_o (status)
   );

   always #5 clk = ~clk;

   // Magnitude as an exact integer in units of 2^-149.
   function automatic logic [VW-1:0] mag(input logic [31:0] x);
      logic [VW-1:0] v;
      v = '0;
      if (x[30:23] == 8'd0) return v;
      v[23:0] = {1'b1, x[22:0]};
      return v << (x[30:23] - 1);
   endfunction

   // Exact sum, then a single round-to-nearest-even to 24 bits.
   task automatic ref_add(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [2:0] st);
      logic na, nb, ia, ib, s;
      logic [VW-1:0] va, vb, m, q, rem, half, one;
      int p, e, k;
      na = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      nb = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      ia = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      ib = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (na || nb || (ia && ib && x[31] != y[31])) begin
         r = 32'h7FC00000; st = 3'd4; return;
      end
      if (ia) begin r = x; st = 3'd5; return; end
      if (ib) begin r = y; st = 3'd5; return; end
      if (x[30:23] == 0 && y[30:23] == 0) begin
         r = {x[31] & y[31], 31'd0}; st = 3'd1; return;
      end
      va = mag(x);
      vb = mag(y);
      if (x[31] == y[31]) begin m = va + vb; s = x[31]; end
      else if (va >= vb)  begin m = va - vb; s = x[31]; end
      else                begin m = vb - va; s = y[31]; end
      if (m == 0) begin r = 32'h0; st = 3'd1; return; end
      p = 0;
      for (int i = 0; i < VW; i++) if (m[i]) p = i;
      e = p - 22;
      one = 1;
      if (p > 23) begin
         k    = p - 23;
         q    = m >> k;
         rem  = m & ((one << k) - one);
         half = one << (k - 1);
         if (rem > half || (rem == half && q[0])) q = q + one;
         if (q[24]) begin q = q >> 1; e = e + 1; end
      end else begin
         q = m << (23 - p);
      end
      if (e >= 255)    begin r = {s, 8'hFF, 23'd0};     st = 3'd2; end
      else if (e <= 0) begin r = {s, 31'd0};            st = 3'd3; end
      else             begin r = {s, e[7:0], q[22:0]};  st = 3'd1; end
   endtask

   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] req_v,
                        input logic [2:0] act_s, input logic [2:0] req_s);
      n_checks++;
      if (act_v === req_v && act_s === req_s) n_pass++;
      else $display("FAIL %s: got %h status %0d, required %h status %0d",
                    name, act_v, act_s, req_v, req_s);
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_ans <= 32'h0;
         exp_st  <= 3'd0;
      end else if (vld) begin
         ref_add(a, b, t_ans, t_st);
         exp_ans <= t_ans;
         exp_st  <= t_st;
      end else begin
         exp_st  <= 3'd0;
      end
   end

   always @(negedge clk) check("cycle", answer, exp_ans, status, exp_st);

   task automatic apply(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ra, input logic [2:0] rs);
      logic [31:0] ma;
      logic [2:0]  ms;
      a = x; b = y; vld = 1'b1;
      @(posedge clk); #1;
      check({name, " dut"}, answer, ra, status, rs);
      ref_add(x, y, ma, ms);
      check({name, " model"}, ma, ra, ms, rs);
   endtask

   initial begin
      logic [31:0] x, y;
      repeat (2) @(posedge clk);
      #1;
      check("reset", answer, 32'h0, status, 3'd0);
      rst = 1'b0;

      apply("add_3p075",   32'h3F600000, 32'h400CCCCD, 32'h4044CCCD, 3'd1);
      apply("cancel",      32'h3F800000, 32'hBF800000, 32'h00000000, 3'd1);
      apply("carry",       32'h3FC00000, 32'h3FC00000, 32'h40400000, 3'd1);
      apply("tie_even",    32'h3F800000, 32'h33800000, 32'h3F800000, 3'd1);
      apply("above_tie",   32'h3F800000, 32'h33800001, 32'h3F800001, 3'd1);
      apply("tie_odd",     32'h3F800001, 32'h33800000, 32'h3F800002, 3'd1);
      apply("ovf_pos",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'd2);
      apply("ovf_neg",     32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000, 3'd2);
      apply("inf_minf",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'd4);
      apply("inf_one",     32'h7F800000, 32'h3F800000, 32'h7F800000, 3'd5);
      apply("one_minf",    32'hBF800000, 32'hFF800000, 32'hFF800000, 3'd5);
      apply("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'd4);
      apply("unf",         32'h00800001, 32'h80800000, 32'h00000000, 3'd3);
      apply("negzeros",    32'h80000000, 32'h80000000, 32'h80000000, 3'd1);
      apply("denorm_zero", 32'h00000001, 32'h80000005, 32'h00000000, 3'd1);
      apply("denorm_add",  32'h3F800000, 32'h00400000, 32'h3F800000, 3'd1);
      apply("sub_norm",    32'h40000000, 32'hBF800000, 32'h3F800000, 3'd1);
      apply("sub_ulp",     32'h3F800001, 32'hBF800000, 32'h34000000, 3'd1);

      a = 32'h40400000; b = 32'h40400000; vld = 1'b0;
      @(posedge clk); #1;
      check("vld_low_hold", answer, 32'h34000000, status, 3'd0);

      apply("pre_reset",   32'h3F800000, 32'h3F800000, 32'h40000000, 3'd1);
      a = 32'h40400000; b = 32'h3F800000; vld = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("async_reset", answer, 32'h0, status, 3'd0);
      @(posedge clk); #1;
      check("reset_hold", answer, 32'h0, status, 3'd0);
      rst = 1'b0;
      apply("post_reset",  32'h40400000, 32'h3F800000, 32'h40800000, 3'd1);

      for (int i = 0; i < 400; i++) begin
         x = $urandom;
         y = $urandom;
         if (i % 2 == 0) y[30:23] = x[30:23] - 8'($urandom_range(0, 3));
         if (i % 5 == 0) y[31] = ~x[31];
         if (i % 7 == 0) y = {~x[31], x[30:0] ^ 31'($urandom_range(0, 255))};
         if (i % 11 == 0) x[30:23] = 8'($urandom_range(250, 254));
         a = x; b = y;
         vld = ($urandom_range(0, 7) != 0);
         @(posedge clk); #1;
      end

      vld = 1'b0;
      @(posedge clk); #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
